// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one single-port memory between instruction fetch and the
//            data stage. Data wins ties, bounded by a streak limit. Optional
//            BUSY timeout is enabled by defining MEM_ARB_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module mem_arbiter #(
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_strb,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_strb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        err
);

    localparam int c_STREAK_W = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);
    localparam logic [c_STREAK_W-1:0] c_STREAK_MAX = c_STREAK_W'(MAX_D_STREAK);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BUSY_I = 2'd1,
        S_BUSY_D = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t                r_state;
    logic [c_STREAK_W-1:0] r_streak;
    logic                  w_grant_d;
    logic                  w_owner_d;

    // Fetch wins a tie only once data has used up its streak allowance.
    assign w_grant_d = d_req && !(i_req && (r_streak == c_STREAK_MAX));
    assign w_owner_d = (r_state == S_BUSY_D);

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int c_TMO_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT - 1);

    logic [c_TMO_W-1:0] r_tmo;
    logic               w_tmo_hit;

    assign w_tmo_hit = (r_tmo == c_TMO_LAST);

    // Held at zero outside BUSY, so every transaction starts counting from 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tmo <= '0;
        end else if (r_state == S_BUSY_I || r_state == S_BUSY_D) begin
            r_tmo <= r_tmo + c_TMO_W'(1);
        end else begin
            r_tmo <= '0;
        end
    end
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT != 0);
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_streak  <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_strb  <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_rvalid  <= 1'b0;
            i_rdata   <= '0;
            d_rvalid  <= 1'b0;
            d_rdata   <= '0;
            busy      <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            err       <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_req || d_req) begin
                        mem_req <= 1'b1;
                        busy    <= 1'b1;
                        if (w_grant_d) begin
                            r_state   <= S_BUSY_D;
                            mem_we    <= d_we;
                            mem_strb  <= d_strb;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                            if (!i_req) begin
                                r_streak <= '0;
                            end else if (r_streak != c_STREAK_MAX) begin
                                r_streak <= r_streak + c_STREAK_W'(1);
                            end
                        end else begin
                            r_state   <= S_BUSY_I;
                            mem_we    <= 1'b0;
                            mem_strb  <= '0;
                            mem_addr  <= i_addr;
                            mem_wdata <= '0;
                            r_streak  <= '0;
                        end
                    end
                end

                S_BUSY_I, S_BUSY_D: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        r_state <= S_RESP;
                        if (w_owner_d) begin
                            d_rvalid <= 1'b1;
                            d_rdata  <= mem_we ? 32'd0 : mem_rdata;
                        end else begin
                            i_rvalid <= 1'b1;
                            i_rdata  <= mem_rdata;
                        end
`ifdef MEM_ARB_TIMEOUT_EN
                    end else if (w_tmo_hit) begin
                        // Abandon the access: complete with zero data and flag it.
                        mem_req <= 1'b0;
                        r_state <= S_RESP;
                        err     <= 1'b1;
                        if (w_owner_d) begin
                            d_rvalid <= 1'b1;
                            d_rdata  <= '0;
                        end else begin
                            i_rvalid <= 1'b1;
                            i_rdata  <= '0;
                        end
`endif
                    end
                end

                S_RESP: begin
                    r_state  <= S_IDLE;
                    busy     <= 1'b0;
                    i_rvalid <= 1'b0;
                    i_rdata  <= '0;
                    d_rvalid <= 1'b0;
                    d_rdata  <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
                    err      <= 1'b0;
`endif
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter: directed vector table, corner
//            sequences and a randomized run against a transaction-level model.
// Revision : 1.0
// ============================================================================
module tb_mem_arbiter;

    localparam int MAXS = 4;
    localparam int TMO  = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [3:0]  d_strb = '0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_strb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        busy;
    logic        err;

    always #5 clk = ~clk;

    mem_arbiter #(.MAX_D_STREAK(MAXS), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_strb(d_strb), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_strb(mem_strb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .busy(busy), .err(err)
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        ir;
        logic [31:0] ia;
        logic        dr;
        logic        dwe;
        logic [3:0]  ds;
        logic [31:0] da;
        logic [31:0] dw;
        int          dly;
        logic [31:0] mrd;
        logic        own_d;
        logic        e_we;
        logic [3:0]  e_strb;
        logic [31:0] e_addr;
        logic [31:0] e_wd;
        logic [31:0] e_rd;
    } vec_t;

    vec_t tv[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " ctl"}, {22'd0, mem_req, mem_we, mem_strb, busy, err, i_rvalid, d_rvalid}, 32'd0);
        chk({tag, " mem_addr"}, mem_addr, 32'd0);
        chk({tag, " mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, " i_rdata"}, i_rdata, 32'd0);
        chk({tag, " d_rdata"}, d_rdata, 32'd0);
    endtask

    // Entered at an IDLE negedge with no request; leaves at the next IDLE negedge.
    task automatic run_vec(input vec_t v, input int idx);
        string t;
        t = $sformatf("v%0d", idx);
        i_req = v.ir; i_addr = v.ia;
        d_req = v.dr; d_we = v.dwe; d_strb = v.ds; d_addr = v.da; d_wdata = v.dw;
        for (int j = 1; j <= v.dly; j++) begin
            @(negedge clk);
            chk({t, " mem_req"}, mem_req, 1'b1);
            chk({t, " busy"}, busy, 1'b1);
            chk({t, " mem_we"}, mem_we, v.e_we);
            chk({t, " mem_strb"}, mem_strb, v.e_strb);
            chk({t, " mem_addr"}, mem_addr, v.e_addr);
            if (v.own_d) chk({t, " mem_wdata"}, mem_wdata, v.e_wd);
            chk({t, " early rvalid"}, {i_rvalid, d_rvalid}, 2'b00);
            mem_ack   = (j == v.dly);
            mem_rdata = (j == v.dly) ? v.mrd : $urandom;
        end
        @(negedge clk);
        mem_ack = 1'b0;
        chk({t, " i_rvalid"}, i_rvalid, !v.own_d);
        chk({t, " d_rvalid"}, d_rvalid, v.own_d);
        chk({t, " rdata"}, v.own_d ? d_rdata : i_rdata, v.e_rd);
        chk({t, " resp mem_req"}, mem_req, 1'b0);
        chk({t, " resp err"}, err, 1'b0);
        i_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        chk({t, " idle busy"}, busy, 1'b0);
        chk({t, " idle rvalid"}, {i_rvalid, d_rvalid}, 2'b00);
    endtask

    // Called in the first BUSY cycle: ack at once, return at the RESP negedge.
    task automatic serve(input logic own_d, input logic [31:0] rd, input logic [31:0] e_rd, input string tag);
        mem_ack = 1'b1; mem_rdata = rd;
        @(negedge clk);
        mem_ack = 1'b0;
        chk({tag, " i_rvalid"}, i_rvalid, !own_d);
        chk({tag, " d_rvalid"}, d_rvalid, own_d);
        chk({tag, " rdata"}, own_d ? d_rdata : i_rdata, e_rd);
        chk({tag, " mem_req drop"}, mem_req, 1'b0);
        chk({tag, " err"}, err, 1'b0);
    endtask

    task automatic wait_grant(input string tag);
        int k;
        k = 0;
        @(negedge clk);
        while (mem_req !== 1'b1 && k < 8) begin
            @(negedge clk);
            k++;
        end
        chk({tag, " grant"}, mem_req, 1'b1);
    endtask

    // Transaction-level model: phase 0 idle, 1 access in flight, 2 completion.
    task automatic run_random(input int ncyc);
        logic        pi = 1'b0, pd = 1'b0, dwe = 1'b0, own_d = 1'b0, e_we = 1'b0, ack_d = 1'b0;
        logic [3:0]  ds = '0, e_strb = '0;
        logic [31:0] ia = '0, da = '0, dw = '0, ack_data = '0, e_addr = '0, e_wd = '0, e_rd = '0;
        int          ph = 0, cnt = 0, streak = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            case (ph)
                0: if (pi || pd) begin
                    own_d = pd && !(pi && streak == MAXS);
                    if (own_d && pi) streak = (streak < MAXS) ? streak + 1 : MAXS;
                    else streak = 0;
                    e_we   = own_d ? dwe : 1'b0;
                    e_strb = own_d ? ds : 4'h0;
                    e_addr = own_d ? da : ia;
                    e_wd   = dw;
                    cnt    = $urandom_range(0, 3);
                    ph     = 1;
                end
                1: if (ack_d) begin
                    ph   = 2;
                    e_rd = (own_d && e_we) ? 32'd0 : ack_data;
                end
                default: ph = 0;
            endcase
            chk("rnd busy", busy, ph != 0);
            chk("rnd mem_req", mem_req, ph == 1);
            chk("rnd i_rvalid", i_rvalid, ph == 2 && !own_d);
            chk("rnd d_rvalid", d_rvalid, ph == 2 && own_d);
            chk("rnd err", err, 1'b0);
            if (ph == 1) begin
                chk("rnd mem_we", mem_we, e_we);
                chk("rnd mem_strb", mem_strb, e_strb);
                chk("rnd mem_addr", mem_addr, e_addr);
                if (own_d) chk("rnd mem_wdata", mem_wdata, e_wd);
            end
            if (ph == 2) begin
                chk("rnd rdata", own_d ? d_rdata : i_rdata, e_rd);
                if (own_d) pd = 1'b0; else pi = 1'b0;
            end
            if (!pi && $urandom_range(0, 1) == 0) begin
                pi = 1'b1;
                ia = $urandom & 32'hFFFF_FFFC;
            end
            if (!pd && $urandom_range(0, 1) == 0) begin
                pd  = 1'b1;
                dwe = 1'($urandom_range(0, 1));
                ds  = 4'($urandom);
                da  = $urandom;
                dw  = $urandom;
            end
            if (ph == 1) begin
                if (cnt == 0) ack_d = 1'b1;
                else begin ack_d = 1'b0; cnt--; end
            end else begin
                ack_d = ($urandom_range(0, 3) == 0);
            end
            ack_data = $urandom;
            mem_ack = ack_d; mem_rdata = ack_data;
            i_req = pi; i_addr = ia;
            d_req = pd; d_we = dwe; d_strb = ds; d_addr = da; d_wdata = dw;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic exp_own[6];
        exp_own = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

        tv[0] = '{1'b1, 32'h40, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1, 32'h2408_0005,
                  1'b0, 1'b0, 4'h0, 32'h40, 32'h0, 32'h2408_0005};
        tv[1] = '{1'b1, 32'h44, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0, 2, 32'h1111_2222,
                  1'b1, 1'b0, 4'hF, 32'h100, 32'h0, 32'h1111_2222};
        tv[2] = '{1'b1, 32'h44, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1, 32'hAAAA_5555,
                  1'b0, 1'b0, 4'h0, 32'h44, 32'h0, 32'hAAAA_5555};
        tv[3] = '{1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h200, 32'hCAFE_BABE, 3, 32'hDEAD_BEEF,
                  1'b1, 1'b1, 4'b0011, 32'h200, 32'hCAFE_BABE, 32'h0};
        tv[4] = '{1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h3FC, 32'h0, 5, 32'h0BAD_F00D,
                  1'b1, 1'b0, 4'hF, 32'h3FC, 32'h0, 32'h0BAD_F00D};
        tv[5] = '{1'b1, 32'h80, 1'b1, 1'b1, 4'b1100, 32'h10, 32'h1234_5678, 2, 32'h7777_7777,
                  1'b1, 1'b1, 4'b1100, 32'h10, 32'h1234_5678, 32'h0};
        tv[6] = '{1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 4, 32'hFFFF_FFFF,
                  1'b0, 1'b0, 4'h0, 32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFFF};

        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 7; v++) run_vec(tv[v], v);

        // Simultaneous requests: data first, fetch picked up in the next IDLE.
        i_req = 1'b1; i_addr = 32'h48;
        d_req = 1'b1; d_we = 1'b0; d_strb = 4'hF; d_addr = 32'h100; d_wdata = 32'h0;
        @(negedge clk);
        chk("simul first addr", mem_addr, 32'h100);
        serve(1'b1, 32'h5A5A_0001, 32'h5A5A_0001, "simul D");
        d_req = 1'b0;
        @(negedge clk);
        chk("simul idle mem_req", mem_req, 1'b0);
        @(negedge clk);
        chk("simul I grant", mem_req, 1'b1);
        chk("simul I addr", mem_addr, 32'h48);
        chk("simul I we", mem_we, 1'b0);
        serve(1'b0, 32'h0000_1234, 32'h0000_1234, "simul I");
        i_req = 1'b0;
        @(negedge clk);

        // Starvation guard with both sides requesting continuously.
        i_req = 1'b1; i_addr = 32'h500;
        d_req = 1'b1; d_we = 1'b0; d_strb = 4'hF; d_addr = 32'h300;
        mem_ack = 1'b0;
        @(negedge clk);
        for (int n = 0; n < 6; n++) begin
            if (n > 0) wait_grant($sformatf("starve%0d", n));
            chk($sformatf("starve%0d owner addr", n), mem_addr, exp_own[n] ? 32'h300 : 32'h500);
            serve(exp_own[n], 32'h100 + n, 32'h100 + n, $sformatf("starve%0d", n));
        end
        i_req = 1'b0; d_req = 1'b0;
        @(negedge clk);

        // Asynchronous reset in the middle of a data store.
        d_req = 1'b1; d_we = 1'b1; d_strb = 4'hF; d_addr = 32'h240; d_wdata = 32'h1357_2468;
        @(negedge clk);
        chk("rstmid busy1", mem_req, 1'b1);
        @(negedge clk);
        #2 reset = 1'b0;
        #1 chk_all_zero("rstmid async");
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_0000;
        repeat (2) begin
            @(negedge clk);
            chk("rstmid no rvalid", {i_rvalid, d_rvalid, mem_req}, 3'b000);
        end
        reset = 1'b1; mem_ack = 1'b0;
        wait_grant("rstmid regrant");
        chk("rstmid addr", mem_addr, 32'h240);
        chk("rstmid we", mem_we, 1'b1);
        chk("rstmid wdata", mem_wdata, 32'h1357_2468);
        serve(1'b1, 32'h0000_0099, 32'h0, "rstmid");
        d_req = 1'b0;
        @(negedge clk);

`ifdef MEM_ARB_TIMEOUT_EN
        begin
            int cyc;
            cyc = 0;
            d_req = 1'b1; d_we = 1'b0; d_strb = 4'hF; d_addr = 32'h600;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (mem_req !== 1'b1) break;
                cyc++;
            end
            chk("tmo busy cycles", cyc, TMO);
            chk("tmo d_rvalid", d_rvalid, 1'b1);
            chk("tmo err", err, 1'b1);
            chk("tmo d_rdata", d_rdata, 32'h0);
            d_req = 1'b0;
            @(negedge clk);
            chk("tmo err clear", {err, d_rvalid}, 2'b00);
            d_req = 1'b1;
            for (int j = 1; j <= TMO; j++) begin
                @(negedge clk);
                mem_ack = (j == TMO); mem_rdata = 32'h7E57_0008;
            end
            @(negedge clk);
            mem_ack = 1'b0;
            chk("tmo ackwins rvalid", d_rvalid, 1'b1);
            chk("tmo ackwins err", err, 1'b0);
            chk("tmo ackwins rdata", d_rdata, 32'h7E57_0008);
            d_req = 1'b0;
            @(negedge clk);
        end
`endif

        run_random(3000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
